regfile_stream_ctrl: RTL

REGFILE_STREAM_CTRL -- requirements
Module: regfile_stream_ctrl
Drives the write port and read port A of the latch-based register file: accepts a write stream, issues RF writes, and on command dumps all words as a read stream.

---
 rtl/regfile_stream_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/regfile_stream_ctrl.sv
// Write-stream front end and full-readout sequencer for the latch-based register file.
// Writes go straight to the RF write port while idle. A dump request waits out the RF
// write latency, then streams every word out through a single-entry output register.
module regfile_stream_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DataWidth  = 16
) (
  input  logic                  clk_int,
  input  logic                  rst_ni,
  // write stream
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DataWidth-1:0]  wr_data_i,
  // control / status
  input  logic                  dump_start_i,
  output logic                  busy_o,
  output logic                  err_o,
  // readout stream
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [DataWidth-1:0]  rd_data_o,
  // RF write port
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DataWidth-1:0]  rf_wdata_o,
  // RF read port A
  output logic [ADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [DataWidth-1:0]  rf_rdata_i
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DUMP   = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  settle_q, settle_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DataWidth-1:0]  rd_data_q, rd_data_d;
  logic                  err_q, err_d;
  logic                  wr_hs;
  logic                  load;

  // Handshake and load qualifiers shared by next-state logic and RF port outputs.
  always_comb begin
    wr_hs = wr_valid_i & (state_q == IDLE);
    load  = (state_q == DUMP) & (~rd_valid_q | rd_ready_i);
  end

  // Next-state, read pointer, settle counter, output register and sticky error.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    settle_d   = settle_q;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    err_d      = err_q | (wr_hs & (wr_addr_i == '0));

    case (state_q)
      IDLE: begin
        if (dump_start_i) begin
          state_d  = SETTLE;
          settle_d = 1'b0;
          ptr_d    = '0;
        end
      end
      SETTLE: begin
        // Two cycles let the last accepted write reach the RF latches.
        settle_d = 1'b1;
        if (settle_q) begin
          state_d  = DUMP;
          settle_d = 1'b0;
          ptr_d    = '0;
        end
      end
      DUMP: begin
        if (load) begin
          rd_valid_d = 1'b1;
          rd_addr_d  = ptr_q;
          rd_data_d  = rf_rdata_i;
          if (ptr_q == LastAddr) begin
            state_d = DRAIN;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (~rd_valid_q | rd_ready_i) begin
          rd_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      settle_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      settle_q   <= settle_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
    end
  end

  // Port mapping; the RF write port is a direct pass-through of the accepted write.
  always_comb begin
    wr_ready_o = (state_q == IDLE);
    busy_o     = (state_q != IDLE);
    err_o      = err_q;
    rd_valid_o = rd_valid_q;
    rd_addr_o  = rd_addr_q;
    rd_data_o  = rd_data_q;
    rf_we_o    = wr_hs & (wr_addr_i != '0);
    rf_waddr_o = wr_addr_i;
    rf_wdata_o = wr_data_i;
    rf_raddr_o = (state_q == DUMP) ? ptr_q : '0;
  end

endmodule
